// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the bus cycle arbiter: FSM states, default
// sizes and a one-hot helper used when a requester is granted.
package bus_arb_pkg;

   localparam int N_REQ_DEF  = 4;
   localparam int WAIT_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      WAIT = 2'd2,
      DATA = 2'd3
   } state_t;

   // One-hot vector for an index; callers slice down to their own width.
   function automatic logic [31:0] onehot(input int idx);
      logic [31:0] v;
      v = 32'd0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request scanning upward
// from the slot after last_owner, wrapping at N_REQ.
module rr_pick
   import bus_arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEF,
   parameter int OWN_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [OWN_W-1:0] last_owner,
   output logic             valid,
   output logic [OWN_W-1:0] sel
);

   int idx;

   always_comb begin
      valid = 1'b0;
      sel   = '0;
      idx   = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_owner) + k) % N_REQ;
         if (!valid && req[idx]) begin
            valid = 1'b1;
            sel   = OWN_W'(idx);
         end
      end
   end

endmodule

// File: rtl/bus_cycle_arbiter.sv
// Round-robin bus arbiter that walks each granted transfer through address,
// programmable wait and data phases, with a one-cycle turnaround afterwards.
module bus_cycle_arbiter
   import bus_arb_pkg::*;
#(
   parameter int N_REQ  = N_REQ_DEF,
   parameter int WAIT_W = WAIT_W_DEF,
   parameter int OWN_W  = $clog2(N_REQ)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_REQ-1:0]  req,
   input  logic [WAIT_W-1:0] wait_cfg,
   output logic [N_REQ-1:0]  gnt,
   output logic [OWN_W-1:0]  owner,
   output logic              ale,
   output logic              data_phase,
   output logic              done,
   output logic              busy
);

   // Handshake: req is a level request sampled only in IDLE; once granted,
   // gnt holds from the grant edge through DATA whatever req does, and drops
   // for the mandatory turnaround cycle before the next grant.
   state_t            state, state_d;
   logic [WAIT_W-1:0] cnt, cnt_d;
   logic [OWN_W-1:0]  last_owner, last_d, owner_d;
   logic [N_REQ-1:0]  gnt_d;
   logic              pick_valid;
   logic [OWN_W-1:0]  pick_sel;
   logic [31:0]       sel_onehot;

   rr_pick #(.N_REQ(N_REQ), .OWN_W(OWN_W)) u_pick (
      .req        (req),
      .last_owner (last_owner),
      .valid      (pick_valid),
      .sel        (pick_sel)
   );

   assign sel_onehot = onehot(int'(pick_sel));

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      gnt_d   = gnt;
      owner_d = owner;
      last_d  = last_owner;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               state_d = ADDR;
               gnt_d   = sel_onehot[N_REQ-1:0];
               owner_d = pick_sel;
               last_d  = pick_sel;
               cnt_d   = wait_cfg;
            end
         end
         ADDR: state_d = (cnt != '0) ? WAIT : DATA;
         WAIT: begin
            // Counter saturates at zero; leaving on 1 gives exactly wait_cfg cycles.
            if (cnt != '0) cnt_d = cnt - WAIT_W'(1);
            if (cnt <= WAIT_W'(1)) state_d = DATA;
         end
         DATA: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         gnt        <= '0;
         owner      <= '0;
         last_owner <= OWN_W'(N_REQ - 1);
         ale        <= 1'b0;
         data_phase <= 1'b0;
         done       <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         gnt        <= gnt_d;
         owner      <= owner_d;
         last_owner <= last_d;
         ale        <= (state_d == ADDR);
         data_phase <= (state_d == DATA);
         done       <= (state_d == DATA);
         busy       <= (state_d != IDLE);
      end
   end

endmodule

// File: doc/bus_cycle_arbiter.md
Name: bus_cycle_arbiter

Overview:
Shares one system bus among N_REQ requesters and sequences each granted transfer through address, wait and data phases. Each transfer uses a programmable wait-state count. This block replaces the fixed 16-cycle ready delay with a per-transfer count and adds round-robin ownership. It sits between the requesting masters and the bus drivers, which use gnt/ale/data_phase to enable their outputs.

Parameters:
N_REQ, 4, number of requesters (>= 2)
WAIT_W, 4, width of the wait-state count (maximum 2^WAIT_W-1 wait cycles)
OWN_W, $clog2(N_REQ), width of the owner index

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester bus request, level
wait_cfg  input  WAIT_W  wait states for the next transfer, sampled at grant
gnt  output  N_REQ  one-hot grant, held for the whole transfer
owner  output  OWN_W  binary index of the current or last owner
ale  output  1  address-phase strobe, one cycle per transfer
data_phase  output  1  high during the data cycle
done  output  1  one-cycle pulse, coincident with data_phase
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, active-high) clears the following: state=IDLE, gnt=0, owner=0, ale=0, data_phase=0, done=0, busy=0, wait counter=0, last_owner=N_REQ-1 (so requester 0 has priority first).
- All outputs are registered. No combinational path from req to gnt.
- States: IDLE, ADDR, WAIT, DATA.
- IDLE: if req!=0, select the first asserted bit scanning from last_owner+1 upward with wrap.
  - Next edge: state=ADDR, gnt=onehot(sel), owner=sel, last_owner=sel, counter=wait_cfg, ale=1, busy=1.
  - If req==0, stay in IDLE.
- ADDR: lasts one cycle.
  - Next: WAIT if counter!=0; otherwise DATA.
- WAIT: the counter decrements every cycle. Leave when the counter reaches 0, giving exactly wait_cfg cycles in WAIT.
  - Next: DATA.
- DATA: lasts one cycle; data_phase=1 and done=1.
  - Next: IDLE with gnt=0 and busy=0. This is the mandatory one-cycle turnaround; a new grant can occur at the earliest on the following edge.
- Latency: the edge that samples req in IDLE also raises ale. done is high exactly wait_cfg+1 cycles after ale. Bus occupancy is wait_cfg+2 cycles plus 1 turnaround cycle.
- No abort: if req deasserts after grant, the transfer still completes and done pulses. A wait_cfg change after the grant edge is ignored.
- Simultaneous requests: only round-robin order decides. Requests arriving during a transfer wait for IDLE.
- A requester holding req continuously still yields to any other pending requester. Worst-case wait is (N_REQ-1) transfers.
- The counter never wraps: it stops at 0. wait_cfg=all-ones gives 2^WAIT_W-1 wait cycles (15 at default).
- Reset mid-transfer clears the outputs immediately (asynchronously). No done pulse is emitted for the aborted transfer.

Decomposition:
- Package bus_arb_pkg: state enum (IDLE, ADDR, WAIT, DATA), default parameter constants, and a onehot/index helper function.
- Sub-module rr_pick: a combinational round-robin priority picker. Inputs are req and last_owner; outputs are a valid flag and the selected index. It is instantiated once. All state, counter and output registers stay in bus_cycle_arbiter.

Test Plan:
1. After reset, req=0001, wait_cfg=3 -> ale=1, gnt=0001, owner=0 one cycle after sampling. WAIT lasts 3 cycles, then data_phase=done=1 for 1 cycle (4 cycles after ale), then gnt=0 and busy=0.
2. req=0100, wait_cfg=0 -> state goes ADDR then DATA directly. done is asserted 1 cycle after ale.
3. req=1111 held, wait_cfg=1 -> grants go 0,1,2,3,0 in order. Each transfer occupies 4 cycles including turnaround, and gnt is never multi-hot.
4. req=0010, wait_cfg=15 -> 15 WAIT cycles. done is asserted 16 cycles after ale.
5. req=0001 granted with wait_cfg=5; drop req and change wait_cfg to 1 during WAIT -> still 5 WAIT cycles and done pulses once.
6. Assert reset during WAIT -> all outputs are 0 immediately with no done pulse. After release with req=1000 and req=0001 both asserted, requester 0 is granted first.
